pay_station: RTL and testbench

Entry/exit ticket and payment kiosk for the parking lot. It is the counterpart to the lot controller: it issues the ticket pulse (`Tick_1`) that the controller waits on in its take-ticket state. It times the stay and computes a saturating fee. It collects coin pulses and returns the `paid_stat` pulse that releases the controller from its pay state. One car is handled at a time. A running revenue total is kept for the display path.

---
 rtl/pay_station_if.sv | 22 ++
 rtl/pay_station.sv | 103 ++++++++++
 tb/tb_pay_station.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pay_station_if.sv
// Kiosk-side signal bundle between the pay station and the lot controller/entry hardware.
// The slave modport is the pay station; the master modport drives the requests and coins.
interface pay_station_if;
  logic       tick_req;
  logic       exit_req;
  logic       coin;
  logic       Tick_1;
  logic       paid_stat;
  logic [3:0] fee_due;
  logic       busy;
  logic [7:0] revenue;

  modport master (
    output tick_req, exit_req, coin,
    input  Tick_1, paid_stat, fee_due, busy, revenue
  );

  modport slave (
    input  tick_req, exit_req, coin,
    output Tick_1, paid_stat, fee_due, busy, revenue
  );
endinterface

// File: rtl/pay_station.sv
// Parking ticket/payment kiosk: issues a ticket, times the stay into a saturating fee,
// collects coins until the balance is cleared, and keeps a wrapping revenue total.
module pay_station #(
  parameter int UNIT_CYCLES = 8,
  parameter int RATE        = 2,
  parameter int MAX_FEE     = 15
) (
  input  logic         clk,
  input  logic         reset,
  pay_station_if.slave bus
);

  localparam int CNT_W = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [4:0]       RATE_W   = 5'(RATE);
  localparam logic [4:0]       MAX_W    = 5'(MAX_FEE);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    TIMING,
    COLLECT,
    PAID
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [3:0]       fee_q, fee_d;
  logic [7:0]       revenue_q, revenue_d;
  logic [4:0]       fee_sum;

  // Widened so a step past 15 is seen before it can wrap.
  assign fee_sum = {1'b0, fee_q} + RATE_W;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    fee_d     = fee_q;
    revenue_d = revenue_q;

    unique case (state_q)
      IDLE: begin
        fee_d = 4'd0;
        if (bus.tick_req) state_d = ISSUE;
      end

      ISSUE: begin
        cyc_cnt_d = '0;
        fee_d     = RATE_W[3:0];
        state_d   = TIMING;
      end

      TIMING: begin
        cyc_cnt_d = (cyc_cnt_q == CNT_LAST) ? '0 : cyc_cnt_q + 1'b1;
        // Exit takes priority: the fee leaves with its pre-wrap value.
        if (bus.exit_req) begin
          state_d = COLLECT;
        end else if (cyc_cnt_q == CNT_LAST) begin
          fee_d = (fee_sum > MAX_W) ? MAX_W[3:0] : fee_sum[3:0];
        end
      end

      COLLECT: begin
        if (bus.coin) begin
          revenue_d = revenue_q + 8'd1;
          if (fee_q <= 4'd1) begin
            fee_d   = 4'd0;
            state_d = PAID;
          end else begin
            fee_d = fee_q - 4'd1;
          end
        end
      end

      PAID: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
      fee_q     <= 4'd0;
      revenue_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      fee_q     <= fee_d;
      revenue_q <= revenue_d;
    end
  end

  assign bus.Tick_1    = (state_q == ISSUE);
  assign bus.paid_stat = (state_q == PAID);
  assign bus.busy      = (state_q != IDLE);
  assign bus.fee_due   = fee_q;
  assign bus.revenue   = revenue_q;

endmodule

// File: tb/tb_pay_station.sv
// Directed bench for pay_station with default parameters (8 cycles/unit, rate 2, cap 15).
module tb_pay_station;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  pay_station_if bus ();

  pay_station dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_idle(input string tag, input logic [31:0] rev);
    check({tag, ".tick"}, 32'(bus.Tick_1), 0);
    check({tag, ".paid"}, 32'(bus.paid_stat), 0);
    check({tag, ".busy"}, 32'(bus.busy), 0);
    check({tag, ".fee"}, 32'(bus.fee_due), 0);
    check({tag, ".rev"}, 32'(bus.revenue), rev);
  endtask

  function automatic int exp_fee(input int k);
    int f;
    f = 2 * (1 + k / 8);
    return (f > 15) ? 15 : f;
  endfunction

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.tick_req = 1'b0;
    bus.exit_req = 1'b0;
    bus.coin     = 1'b0;

    // Reset state
    step(); step();
    check_idle("reset", 0);
    reset = 1'b0;
    step();
    check_idle("post_reset", 0);

    // Basic flow
    bus.tick_req = 1'b1;
    step();
    check("basic.issue_tick", 32'(bus.Tick_1), 1);
    check("basic.issue_busy", 32'(bus.busy), 1);
    check("basic.issue_fee", 32'(bus.fee_due), 0);
    bus.tick_req = 1'b0;
    step();
    check("basic.t0_tick", 32'(bus.Tick_1), 0);
    check("basic.t0_fee", 32'(bus.fee_due), 2);
    bus.coin     = 1'b1;
    bus.tick_req = 1'b1;
    step();
    check("basic.t1_rev", 32'(bus.revenue), 0);
    check("basic.t1_fee", 32'(bus.fee_due), 2);
    check("basic.t1_tick", 32'(bus.Tick_1), 0);
    bus.coin     = 1'b0;
    bus.tick_req = 1'b0;
    step();
    bus.exit_req = 1'b1;
    step();
    bus.exit_req = 1'b0;
    check("basic.collect_fee", 32'(bus.fee_due), 2);
    check("basic.collect_busy", 32'(bus.busy), 1);
    bus.tick_req = 1'b1;
    step();
    bus.tick_req = 1'b0;
    check("basic.collect_tick_ign", 32'(bus.fee_due), 2);
    check("basic.collect_no_tick", 32'(bus.Tick_1), 0);
    bus.coin = 1'b1;
    step();
    check("basic.coin1_fee", 32'(bus.fee_due), 1);
    check("basic.coin1_rev", 32'(bus.revenue), 1);
    check("basic.coin1_paid", 32'(bus.paid_stat), 0);
    step();
    check("basic.coin2_fee", 32'(bus.fee_due), 0);
    check("basic.coin2_rev", 32'(bus.revenue), 2);
    check("basic.paid", 32'(bus.paid_stat), 1);
    check("basic.paid_busy", 32'(bus.busy), 1);
    step();  // coin still high across PAID: must not be counted
    bus.coin = 1'b0;
    check_idle("basic.idle", 2);

    // Exit and coin in IDLE are ignored
    bus.exit_req = 1'b1;
    bus.coin     = 1'b1;
    step();
    step();
    bus.exit_req = 1'b0;
    bus.coin     = 1'b0;
    check_idle("idle_ignore", 2);

    // Accrual over 20 TIMING cycles
    bus.tick_req = 1'b1;
    step();
    bus.tick_req = 1'b0;
    step();
    for (int k = 0; k < 20; k++) begin
      check($sformatf("accr.k%0d", k), 32'(bus.fee_due), exp_fee(k));
      if (k < 19) step();
    end
    bus.exit_req = 1'b1;
    step();
    bus.exit_req = 1'b0;
    check("accr.collect_fee", 32'(bus.fee_due), 6);
    bus.coin = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("accr.coin%0d_fee", i), 32'(bus.fee_due), 6 - i);
      check($sformatf("accr.coin%0d_paid", i), 32'(bus.paid_stat), (i == 6) ? 1 : 0);
    end
    bus.coin = 1'b0;
    check("accr.rev", 32'(bus.revenue), 8);
    step();
    check_idle("accr.idle", 8);

    // Exit on the wrap cycle keeps the pre-increment fee
    bus.tick_req = 1'b1;
    step();
    bus.tick_req = 1'b0;
    step();
    repeat (7) step();
    check("wrap.k7_fee", 32'(bus.fee_due), 2);
    bus.exit_req = 1'b1;
    step();
    bus.exit_req = 1'b0;
    check("wrap.collect_fee", 32'(bus.fee_due), 2);
    bus.coin = 1'b1;
    step();
    step();
    bus.coin = 1'b0;
    check("wrap.paid", 32'(bus.paid_stat), 1);
    check("wrap.rev", 32'(bus.revenue), 10);
    step();

    // Reset in the middle of COLLECT with fee 4
    bus.tick_req = 1'b1;
    step();
    bus.tick_req = 1'b0;
    step();
    repeat (8) step();
    check("rst.k8_fee", 32'(bus.fee_due), 4);
    bus.exit_req = 1'b1;
    step();
    bus.exit_req = 1'b0;
    check("rst.collect_fee", 32'(bus.fee_due), 4);
    check("rst.collect_rev", 32'(bus.revenue), 10);
    #2;
    reset = 1'b1;
    #1;
    check_idle("rst.async", 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("rst.hold%0d", i), 0);
    end
    reset = 1'b0;
    step();
    check_idle("rst.release", 0);

    // Saturation with tick_req held through TIMING (no re-trigger)
    bus.tick_req = 1'b1;
    step();
    check("sat.issue_tick", 32'(bus.Tick_1), 1);
    step();
    for (int k = 0; k < 120; k++) begin
      check($sformatf("sat.k%0d", k), 32'(bus.fee_due), exp_fee(k));
      if (k == 3) check("sat.no_retrigger", 32'(bus.Tick_1), 0);
      if (k < 119) step();
    end
    bus.tick_req = 1'b0;
    bus.exit_req = 1'b1;
    step();
    bus.exit_req = 1'b0;
    check("sat.collect_fee", 32'(bus.fee_due), 15);
    bus.coin = 1'b1;
    repeat (14) step();
    check("sat.coin14_fee", 32'(bus.fee_due), 1);
    check("sat.coin14_paid", 32'(bus.paid_stat), 0);
    step();
    bus.coin = 1'b0;
    check("sat.paid", 32'(bus.paid_stat), 1);
    check("sat.rev", 32'(bus.revenue), 15);

    // Back-to-back: tick_req already high during PAID
    bus.tick_req = 1'b1;
    step();
    check("b2b.idle_busy", 32'(bus.busy), 0);
    check("b2b.idle_tick", 32'(bus.Tick_1), 0);
    step();
    check("b2b.issue_tick", 32'(bus.Tick_1), 1);
    bus.tick_req = 1'b0;
    step();
    check("b2b.t0_fee", 32'(bus.fee_due), 2);
    check("b2b.t0_tick", 32'(bus.Tick_1), 0);
    bus.exit_req = 1'b1;
    step();
    bus.exit_req = 1'b0;
    bus.coin     = 1'b1;
    step();
    step();
    bus.coin = 1'b0;
    check("b2b.paid", 32'(bus.paid_stat), 1);
    check("b2b.rev", 32'(bus.revenue), 17);
    step();
    check_idle("b2b.idle", 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
